user_tally: RTL and testbench

Counts the player's button presses during a symbol-counting round and supplies the running tally to the answer-period stage. Sits directly upstream of the answer-period block:
- drives its `userCount` input;
- obeys its `stopCount` pulse to freeze the tally once the answer is posted.

Includes synchroniser and debouncer for the raw push-button, plus incremental BCD digits so downstream display needs no divide/modulo.

---
 rtl/symcount_pkg.sv | 32 +++
 rtl/button_debounce.sv | 53 +++++
 rtl/user_tally.sv | 94 +++++++++
 tb/tb_user_tally.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/symcount_pkg.sv
// Shared types and constants for the symbol-counting round logic.
package symcount_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    localparam int COUNT_W           = 7;
    localparam int BCD_W             = 4;
    localparam int MAX_COUNT_DEFAULT = 99;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_t;

    // Two-digit BCD increment; caller guarantees the value is below 99.
    function automatic bcd_t bcd_inc(input bcd_t val);
        bcd_t res;
        if (val.ones == BCD_W'(9)) begin
            res.ones = '0;
            res.tens = val.tens + 1'b1;
        end else begin
            res.ones = val.ones + 1'b1;
            res.tens = val.tens;
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end: 2-flop synchroniser, level debouncer and press (rising edge) detector.
// Presses are only reported once the synchronised button has been seen released after reset.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clk100M,
    input  logic Reset,
    input  logic btnRaw,
    output logic pressEvent
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btnMeta;
    logic             btnSync;
    logic             btnStable;
    logic             btnStableQ;
    logic             armed;
    logic [1:0]       syncFill;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            btnMeta    <= 1'b0;
            btnSync    <= 1'b0;
            btnStable  <= 1'b0;
            btnStableQ <= 1'b0;
            armed      <= 1'b0;
            syncFill   <= 2'b00;
            cnt        <= '0;
        end else begin
            btnMeta    <= btnRaw;
            btnSync    <= btnMeta;
            btnStableQ <= btnStable;
            syncFill   <= {syncFill[0], 1'b1};
            // syncFill keeps the reset value of btnSync from arming a button held through reset
            if (syncFill[1] && !btnSync)
                armed <= 1'b1;
            if (btnSync == btnStable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btnStable <= ~btnStable;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pressEvent = btnStable & ~btnStableQ & armed;

endmodule

// File: rtl/user_tally.sv
// Player press tally with binary and BCD outputs, feeding the answer-period stage.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | after reset, tally held, waiting for roundStart
//   COUNTING | press events increment the tally
//   FROZEN   | answer posted, tally held until next roundStart
module user_tally
    import symcount_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = MAX_COUNT_DEFAULT
) (
    input  logic               Clk100M,
    input  logic               Reset,
    input  logic               btnRaw,
    input  logic               roundStart,
    input  logic               stopCount,
    output logic [COUNT_W-1:0] userCount,
    output logic [BCD_W-1:0]   userTens,
    output logic [BCD_W-1:0]   userOnes,
    output logic               countPulse,
    output logic               counting
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    state_t state;
    state_t stateNext;
    logic   pressEvent;
    logic   clearTally;
    logic   incTally;
    bcd_t   bcdNext;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .Clk100M   (Clk100M),
        .Reset     (Reset),
        .btnRaw    (btnRaw),
        .pressEvent(pressEvent)
    );

    always_ff @(posedge Clk100M) begin
        if (Reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (roundStart) stateNext = COUNTING;
            COUNTING: begin
                if (roundStart)     stateNext = COUNTING;
                else if (stopCount) stateNext = FROZEN;
            end
            FROZEN:   if (roundStart) stateNext = COUNTING;
            default:  stateNext = IDLE;
        endcase
    end

    // roundStart outranks everything; stopCount drops a coincident press
    always_comb begin
        clearTally = roundStart;
        incTally   = (state == COUNTING) && pressEvent && !roundStart &&
                     !stopCount && (userCount < MAX_C);
        bcdNext    = bcd_inc('{tens: userTens, ones: userOnes});
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            userCount  <= '0;
            userTens   <= '0;
            userOnes   <= '0;
            countPulse <= 1'b0;
            counting   <= 1'b0;
        end else begin
            countPulse <= incTally;
            counting   <= (stateNext == COUNTING);
            if (clearTally) begin
                userCount <= '0;
                userTens  <= '0;
                userOnes  <= '0;
            end else if (incTally) begin
                userCount <= userCount + 1'b1;
                userTens  <= bcdNext.tens;
                userOnes  <= bcdNext.ones;
            end
        end
    end

endmodule

// File: tb/tb_user_tally.sv
// Self-checking bench for user_tally with a short debounce window.
module tb_user_tally;

    localparam int DB   = 4;
    localparam int MAXC = 99;

    logic       Clk100M = 1'b0;
    logic       Reset, btnRaw, roundStart, stopCount;
    logic [6:0] userCount;
    logic [3:0] userTens, userOnes;
    logic       countPulse, counting;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int model = 0;
    bit modelCounting = 0;
    int expq[$];

    typedef struct {
        int presses;
        int expCount;
        int expTens;
        int expOnes;
    } vec_t;
    vec_t vecs[4];

    user_tally #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(MAXC)) dut (
        .Clk100M   (Clk100M),
        .Reset     (Reset),
        .btnRaw    (btnRaw),
        .roundStart(roundStart),
        .stopCount (stopCount),
        .userCount (userCount),
        .userTens  (userTens),
        .userOnes  (userOnes),
        .countPulse(countPulse),
        .counting  (counting)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: each countPulse must match the next queued tally
    always @(posedge Clk100M) begin
        #1;
        if (countPulse) begin
            pulses++;
            if (expq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                int e;
                e = expq.pop_front();
                chk("pulse_count", int'(userCount), e);
                chk("pulse_tens", int'(userTens), e / 10);
                chk("pulse_ones", int'(userOnes), e % 10);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic expect_press();
        if (modelCounting && model < MAXC) begin
            model++;
            expq.push_back(model);
        end
    endtask

    task automatic press(input int hi = 10, input int lo = 10);
        expect_press();
        btnRaw = 1'b1;
        cycles(hi);
        btnRaw = 1'b0;
        cycles(lo);
    endtask

    task automatic pulse_start();
        roundStart = 1'b1;
        cycles(1);
        roundStart = 1'b0;
        model = 0;
        modelCounting = 1;
    endtask

    task automatic pulse_stop();
        stopCount = 1'b1;
        cycles(1);
        stopCount = 1'b0;
        modelCounting = 0;
    endtask

    task automatic chk_tally(input string name, input int exp);
        chk({name, "_count"}, int'(userCount), exp);
        chk({name, "_tens"}, int'(userTens), exp / 10);
        chk({name, "_ones"}, int'(userOnes), exp % 10);
    endtask

    initial begin
        int p0;
        vecs[0] = '{9, 9, 0, 9};
        vecs[1] = '{1, 10, 1, 0};
        vecs[2] = '{89, 99, 9, 9};
        vecs[3] = '{6, 99, 9, 9};

        Reset = 1'b1; btnRaw = 1'b0; roundStart = 1'b0; stopCount = 1'b0;
        cycles(5);
        chk_tally("reset", 0);
        chk("reset_counting", int'(counting), 0);
        chk("reset_pulse", int'(countPulse), 0);
        Reset = 1'b0;
        cycles(5);

        // 1: clean presses and press latency
        pulse_start();
        chk("start_counting", int'(counting), 1);
        p0 = pulses;
        expect_press();
        btnRaw = 1'b1;
        repeat (6) @(posedge Clk100M);
        #1 chk("latency_early", int'(countPulse), 0);
        @(posedge Clk100M);
        #1 chk("latency_exact", int'(countPulse), 1);
        cycles(4);
        btnRaw = 1'b0;
        cycles(10);
        press();
        press();
        chk_tally("clean3", 3);
        chk("clean3_pulses", pulses - p0, 3);

        // 2: bounce on press gives one increment; short glitch gives none
        p0 = pulses;
        expect_press();
        btnRaw = 1'b1; cycles(2); btnRaw = 1'b0; cycles(1);
        btnRaw = 1'b1; cycles(2); btnRaw = 1'b0; cycles(1);
        btnRaw = 1'b1; cycles(10); btnRaw = 1'b0; cycles(10);
        chk_tally("bounce", 4);
        btnRaw = 1'b1; cycles(3); btnRaw = 1'b0; cycles(10);
        chk_tally("glitch", 4);
        chk("bounce_pulses", pulses - p0, 1);

        // 3: BCD carry and saturation, table driven
        pulse_start();
        chk_tally("restart", 0);
        for (int i = 0; i < 4; i++) begin
            p0 = pulses;
            for (int k = 0; k < vecs[i].presses; k++) press();
            chk($sformatf("vec%0d_count", i), int'(userCount), vecs[i].expCount);
            chk($sformatf("vec%0d_tens", i), int'(userTens), vecs[i].expTens);
            chk($sformatf("vec%0d_ones", i), int'(userOnes), vecs[i].expOnes);
            chk($sformatf("vec%0d_pulses", i), pulses - p0,
                (i == 3) ? 0 : vecs[i].presses);
        end

        // 4: stopCount freezes the tally
        pulse_start();
        for (int k = 0; k < 5; k++) press();
        pulse_stop();
        chk("stop_counting", int'(counting), 0);
        for (int k = 0; k < 4; k++) press();
        chk_tally("frozen", 5);
        pulse_start();
        chk_tally("unfreeze", 0);
        chk("unfreeze_counting", int'(counting), 1);

        // 5: roundStart beats stopCount; stopCount drops a coincident press
        press();
        roundStart = 1'b1; stopCount = 1'b1;
        cycles(1);
        roundStart = 1'b0; stopCount = 1'b0;
        model = 0;
        chk_tally("both", 0);
        chk("both_counting", int'(counting), 1);
        press();
        btnRaw = 1'b1;
        cycles(6);
        stopCount = 1'b1;
        cycles(1);
        stopCount = 1'b0;
        modelCounting = 0;
        cycles(5);
        btnRaw = 1'b0;
        cycles(10);
        chk_tally("coincident", 1);
        chk("coincident_counting", int'(counting), 0);

        // 6: reset mid-debounce with the button held
        pulse_start();
        press();
        press();
        btnRaw = 1'b1;
        cycles(3);
        Reset = 1'b1;
        cycles(3);
        Reset = 1'b0;
        modelCounting = 0;
        model = 0;
        chk_tally("midreset", 0);
        chk("midreset_counting", int'(counting), 0);
        chk("midreset_pulse", int'(countPulse), 0);
        cycles(5);
        pulse_start();
        p0 = pulses;
        cycles(20);
        chk_tally("held", 0);
        chk("held_pulses", pulses - p0, 0);
        btnRaw = 1'b0;
        cycles(10);
        press();
        chk_tally("repress", 1);

        cycles(5);
        chk("queue_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
